// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seven-segment capture slice.
//   SEG_0..SEG_9, SEG_DASH : lit-segment patterns, bit6 = a ... bit0 = g
//   CODE_DASH, CODE_ERR    : non-numeric digit codes
//   cap_state_t            : capture FSM state encoding
//   is_onehot4()           : true when exactly one of four bits is set
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam logic [3:0] CODE_DASH = 4'hE;
  localparam logic [3:0] CODE_ERR  = 4'hF;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } cap_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    logic r;
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_enc.sv
// seg_enc -- combinational seven-segment pattern decoder.
//   seg  : input  [6:0] lit segments, bit6 = a ... bit0 = g
//   code : output [3:0] digit code 0..9, CODE_DASH, or CODE_ERR
//   err  : output       1 when the pattern is not a recognised glyph
// Optional feature macro: SEG_CAPTURE_DASH_EN -- decode the lone g segment
// as a dash (CODE_DASH, no error) instead of treating it as invalid.
module seg_enc
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg)
      SEG_0: begin code = 4'd0; err = 1'b0; end
      SEG_1: begin code = 4'd1; err = 1'b0; end
      SEG_2: begin code = 4'd2; err = 1'b0; end
      SEG_3: begin code = 4'd3; err = 1'b0; end
      SEG_4: begin code = 4'd4; err = 1'b0; end
      SEG_5: begin code = 4'd5; err = 1'b0; end
      SEG_6: begin code = 4'd6; err = 1'b0; end
      SEG_7: begin code = 4'd7; err = 1'b0; end
      SEG_8: begin code = 4'd8; err = 1'b0; end
      SEG_9: begin code = 4'd9; err = 1'b0; end
`ifdef SEG_CAPTURE_DASH_EN
      SEG_DASH: begin code = CODE_DASH; err = 1'b0; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture -- captures the four digits of a scanned seven-segment display
// and presents them as one frame on a valid/ready interface.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   seg_in      : lit segments a..g (bit6 = a)
//   dig_en      : one-hot digit select, bit0 = least significant digit
//   out_data    : four 4-bit digit codes, [3:0] = digit 0
//   out_err     : some digit of the presented frame failed to decode
//   out_valid   : frame presented; out_ready accepts it
//   overrun     : sticky, a complete frame was dropped; ovr_clr clears it
// Parameter STABLE_CYC (2..15): identical samples needed to accept a digit.
// Optional feature macro: SEG_CAPTURE_DASH_EN (see seg_enc).
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_en,
  output logic [15:0] out_data,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        ovr_clr
);

  localparam logic [3:0] STABLE = STABLE_CYC[3:0];

  cap_state_t      state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [6:0]      seg_r, prev_seg;
  logic [3:0]      en_r, prev_en;
  logic            changed;
  logic            cap_we;
  logic [3:0]      seen, seen_nxt;
  logic [3:0][3:0] slot_code;
  logic [3:0]      slot_err;
  logic [3:0]      dec_code;
  logic            dec_err;
  logic            frame_done;
  logic            load_ok;

  // Input register plus a one-cycle-older copy; prev_* is the sample the
  // counter has been accumulating, so a capture writes that value even if
  // the current sample has already moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r    <= '0;
      en_r     <= '0;
      prev_seg <= '0;
      prev_en  <= '0;
    end else begin
      seg_r    <= seg_in;
      en_r     <= dig_en;
      prev_seg <= seg_r;
      prev_en  <= en_r;
    end
  end

  assign changed = (seg_r != prev_seg) || (en_r != prev_en);

  seg_enc u_enc (
    .seg  (prev_seg),
    .code (dec_code),
    .err  (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEEK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The capture fires one cycle after the counter reaches STABLE. If the
  // sample changed in that same cycle, the new sample is evaluated at once
  // rather than parked in HOLD, where the change would already be absorbed
  // into prev_* and go unnoticed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_we    = 1'b0;
    case (state)
      SEEK: begin
        if (is_onehot4(en_r)) begin
          state_nxt = COUNT;
          cnt_nxt   = 4'd1;
        end else begin
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (cnt >= STABLE) begin
          cap_we = 1'b1;
          if (!changed) begin
            state_nxt = HOLD;
          end else if (is_onehot4(en_r)) begin
            state_nxt = COUNT;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = SEEK;
            cnt_nxt   = '0;
          end
        end else if (!is_onehot4(en_r)) begin
          state_nxt = SEEK;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt   = 4'd1;
        end else begin
          cnt_nxt   = 4'(cnt + 4'd1);
        end
      end
      HOLD: begin
        if (changed) begin
          if (is_onehot4(en_r)) begin
            state_nxt = COUNT;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = SEEK;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = SEEK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_code <= '1;
      slot_err  <= '0;
    end else if (cap_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (prev_en[i]) begin
          slot_code[i] <= dec_code;
          slot_err[i]  <= dec_err;
        end
      end
    end
  end

  assign frame_done = (seen == 4'hF);
  assign load_ok    = !out_valid || out_ready;

  // A capture landing on the frame-completion edge belongs to the next
  // frame, so the clear is applied first and the new bit set afterwards.
  always_comb begin
    seen_nxt = frame_done ? '0 : seen;
    if (cap_we) begin
      seen_nxt = seen_nxt | prev_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else begin
      seen <= seen_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '1;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (frame_done && load_ok) begin
      out_data  <= slot_code;
      out_err   <= |slot_err;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (frame_done && !load_ok) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture -- scoreboard bench for seg_capture. Frame expectations are
// queued when a scan is issued; a monitor thread pops and compares on every
// accepted frame. Register-level checks are made directly.
module tb_seg_capture;
  import seg_pkg::*;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        ovr_clr;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seg_capture #(.STABLE_CYC(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame got data=%h err=%b exp none", out_data, out_err);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_err !== e.err) begin
            miscompares++;
            $display("FAIL frame got data=%h err=%b exp data=%h err=%b",
                     out_data, out_err, e.data, e.err);
          end
        end
      end
    end
  endtask

  // Entered #1 after a rising edge; inputs are held across n sampling edges.
  task automatic hold(input logic [6:0] s, input logic [3:0] e, input int n);
    seg_in = s;
    dig_en = e;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(s0, 4'b0001, 6);
    hold(s1, 4'b0010, 6);
    hold(s2, 4'b0100, 6);
    hold(s3, 4'b1000, 6);
  endtask

  task automatic idle(input int n);
    hold('0, 4'b0000, n);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    rst_n     = 1'b0;
    seg_in    = '0;
    dig_en    = '0;
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data",  out_data, 16'hFFFF);
    check("rst_out_err",   16'(out_err), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_overrun",   16'(overrun), 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic scan 1,2,3,4
    exp_q.push_back('{data: 16'h4321, err: 1'b0});
    scan4(SEG_1, SEG_2, SEG_3, SEG_4);
    idle(3);

    // Invalid pattern on digit 2
    exp_q.push_back('{data: 16'h7F10, err: 1'b1});
    scan4(SEG_0, SEG_1, 7'b1010101, SEG_7);
    idle(3);

    // Stability threshold: S-1 samples do not capture
    hold(SEG_3, 4'b0001, S - 1);
    idle(3);
    check("short_hold_seen", 16'(dut.seen), 16'h0);

    // Exactly S samples: capture lands on edge N+1+S
    seg_in = SEG_3;
    dig_en = 4'b0001;
    repeat (S) @(posedge clk);
    #1;
    seg_in = '0;
    dig_en = '0;
    @(posedge clk);
    @(negedge clk);
    check("edge_n_s_seen", 16'(dut.seen), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("edge_n_s1_seen", 16'(dut.seen), 16'h1);
    @(posedge clk);
    #1;

    // Recapture of slot 0 overwrites the earlier 3
    exp_q.push_back('{data: 16'h3219, err: 1'b0});
    hold(SEG_9, 4'b0001, 6);
    hold(SEG_1, 4'b0010, 6);
    hold(SEG_2, 4'b0100, 6);
    hold(SEG_3, 4'b1000, 6);
    idle(3);

    // Backpressure: first frame held, second dropped
    out_ready = 1'b0;
    exp_q.push_back('{data: 16'h4321, err: 1'b0});
    scan4(SEG_1, SEG_2, SEG_3, SEG_4);
    idle(2);
    check("bp_valid_a",   16'(out_valid), 16'h1);
    check("bp_data_a",    out_data, 16'h4321);
    check("bp_overrun_a", 16'(overrun), 16'h0);
    scan4(SEG_5, SEG_6, SEG_7, SEG_8);
    idle(2);
    check("bp_data_b",    out_data, 16'h4321);
    check("bp_err_b",     16'(out_err), 16'h0);
    check("bp_overrun_b", 16'(overrun), 16'h1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check("ovr_clr", 16'(overrun), 16'h0);
    out_ready = 1'b1;
    idle(3);
    check("bp_released_valid", 16'(out_valid), 16'h0);

    // Two enables at once never leave SEEK
    hold(SEG_1, 4'b0011, 10);
    check("multi_en_state", 16'(dut.state), 16'(SEEK));
    check("multi_en_seen",  16'(dut.seen), 16'h0);
    idle(2);

    // Dash pattern on every digit
`ifdef SEG_CAPTURE_DASH_EN
    exp_q.push_back('{data: 16'hEEEE, err: 1'b0});
`else
    exp_q.push_back('{data: 16'hFFFF, err: 1'b1});
`endif
    scan4(SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH);
    idle(3);

    // Reset after three captures discards them
    hold(SEG_9, 4'b0001, 6);
    hold(SEG_9, 4'b0010, 6);
    hold(SEG_9, 4'b0100, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_seen",     16'(dut.seen), 16'h0);
    check("mid_rst_out_data", out_data, 16'hFFFF);
    check("mid_rst_valid",    16'(out_valid), 16'h0);
    check("mid_rst_err",      16'(out_err), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    // Slot 3 first so leftover seen bits would release a frame early
    exp_q.push_back('{data: 16'h8765, err: 1'b0});
    hold(SEG_8, 4'b1000, 6);
    hold(SEG_5, 4'b0001, 6);
    hold(SEG_6, 4'b0010, 6);
    hold(SEG_7, 4'b0100, 6);
    idle(3);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    check("pending_frames", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4, meaning the number of consecutive identical samples (legal range 2..15) required to accept a digit.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port seg_in, input, 7 bits, segments a..g with bit6=a and bit0=g, 1 = lit.
REQ-005 The block SHALL have port dig_en, input, 4 bits, the one-hot digit select of a scanned display; bit0 = least significant digit.
REQ-006 The block SHALL have port out_data, output, 16 bits, four 4-bit digit codes; out_data[3:0] = digit 0.
REQ-007 The block SHALL have port out_err, output, 1 bit, set when any digit in the presented frame decoded as invalid.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning a frame is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-010 The block SHALL have port overrun, output, 1 bit, a sticky frame-dropped flag.
REQ-011 The block SHALL have port ovr_clr, input, 1 bit, a synchronous clear of overrun.

Function
REQ-012 Decode SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; any other pattern -> code 4'hF with per-digit error.
REQ-013 seg_in and dig_en SHALL be registered once; all stability checks SHALL operate on the registered copies.
REQ-014 The FSM SHALL have states SEEK, COUNT and HOLD.
REQ-015 In SEEK, a one-hot registered dig_en SHALL move the FSM to COUNT with the stability counter at 1.
REQ-016 In COUNT, a sample equal to the previous sample SHALL increment the counter.
REQ-017 In COUNT, any change of seg or en SHALL restart the counter at 1; a non-one-hot en SHALL go to SEEK.
REQ-018 When the counter reaches STABLE_CYC, the decoded code and error SHALL be written to the selected slot, its seen bit set, and the FSM SHALL go to HOLD.
REQ-019 In HOLD, the FSM SHALL wait for any change of seg or en, then re-evaluate as from SEEK in that same cycle.
REQ-020 Inputs held constant from edge N SHALL be captured into the slot at edge N+1+STABLE_CYC.
REQ-021 Recapture of an already-seen slot before frame completion SHALL overwrite the code and the error.
REQ-022 When all four seen bits are set, on the next edge: if !out_valid, or out_valid&&out_ready, out_data SHALL take the slots, out_err SHALL take the OR of the slot errors, and out_valid SHALL be 1; otherwise the frame SHALL be dropped and overrun set.
REQ-023 In either case of REQ-022, the seen bits SHALL clear.
REQ-024 out_valid SHALL deassert on out_valid&&out_ready unless a new frame loads in that same cycle.
REQ-025 out_data and out_err SHALL be stable while out_valid&&!out_ready.
REQ-026 If ovr_clr coincides with a drop, overrun SHALL be 1 (set wins).
REQ-027 The counter SHALL saturate at STABLE_CYC; no wrap-around.

Reset
REQ-028 rst_n low SHALL asynchronously force state=SEEK, counter=0, seen=0, slots=4'hF with error clear, out_data=16'hFFFF, out_err=0, out_valid=0, overrun=0.
REQ-029 Reset mid-frame SHALL discard partial captures; the first frame after release SHALL require four fresh captures.

Configuration
REQ-030 With macro SEG_CAPTURE_DASH_EN defined, pattern 0000001 SHALL decode to code 4'hE with no error.
REQ-031 With SEG_CAPTURE_DASH_EN undefined, pattern 0000001 SHALL be invalid (4'hF, error).

Structure
REQ-032 Package seg_pkg SHALL hold the segment pattern constants SEG_0..SEG_9 and SEG_DASH, the code constants CODE_DASH=4'hE and CODE_ERR=4'hF, and the FSM state typedef.
REQ-033 Sub-module seg_enc SHALL implement the combinational pattern -> {code, err} decode, shared by any future decode users.

Verification
REQ-034 Scan 1,2,3,4 (dig_en 0001..1000), each held 6 cycles, out_ready=1 -> one out_valid pulse, out_data=16'h4321, out_err=0.
REQ-035 Digit 2 pattern 1010101 within a frame of otherwise valid digits -> out_data[11:8]=4'hF, out_err=1.
REQ-036 Hold a digit for STABLE_CYC-1 cycles only -> no capture, seen unchanged; hold STABLE_CYC cycles -> capture at edge N+1+STABLE_CYC.
REQ-037 out_ready=0, two complete frames -> first frame held stable, overrun=1; ovr_clr pulse -> overrun=0.
REQ-038 dig_en=0011 for 10 cycles -> no capture, FSM in SEEK.
REQ-039 Pattern 0000001 on all digits -> 16'hEEEE with out_err=0 when SEG_CAPTURE_DASH_EN is defined; 16'hFFFF with out_err=1 when it is not.
REQ-040 Assert rst_n low after three captures, then release and scan 5,6,7,8 -> out_data=16'h8765 with no stale digits.
